mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised memory stage of the 5-stage pipeline. It takes the EX/MEM bundle, performs byte/half/word loads and stores on an internal data memory with optional multi-cycle latency, and registers the MEM/WB bundle for writeback. It adds stall/flush control, misalignment detection and a busy handshake toward the hazard unit.

## Interface
- DATA_W, 32: datapath width; 32 or 64.
- DEPTH, 256: memory depth in DATA_W words; power of two.
- MEM_LAT, 0: extra wait cycles per memory access; 0..7.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_m  in  1  EX/MEM slot holds a real instruction.
- alu_out_m  in  DATA_W  ALU result; byte address for memory ops.
- dm_wd_m  in  DATA_W  store data, right-aligned.
- dm_write_m / dm_read_m  in  1 each  store / load request; never both set.
- size_m  in  2  00 byte, 01 half, 10 word(32), 11 full DATA_W.
- unsigned_m  in  1  zero-extend loads when 1, else sign-extend.
- result_m  in  1  writeback select, passed through.
- rd_m  in  5  destination register.
- reg_write_m  in  1  register write enable.
- stall_i  in  1  freeze stage.
- flush_i  in  1  kill stage contents.
- busy_o  out  1  stage is mid-access; upstream must hold EX/MEM.
- valid_wb, alu_out_wb(DATA_W), dm_rd_out_wb(DATA_W), result_wb, rd_wb(5), reg_write_wb, misalign_wb  out  MEM/WB register.

## Operation
- Word index = alu_out_m[ADDR_LSB +: log2(DEPTH)], ADDR_LSB = log2(DATA_W/8); upper address bits are ignored, so addresses wrap.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; size 11 needs addr[ADDR_LSB-1:0]=0. Size 11 with DATA_W=32 is treated as word.
- A misaligned memory op performs no write and no wait. It produces misalign_wb=1, reg_write_wb=0 and dm_rd_out_wb=0.
- Store: only the addressed byte lanes are written. The low bytes of dm_wd_m are placed in the addressed lane.
- Load: the addressed lane is extracted and extended per unsigned_m. Non-loads give dm_rd_out_wb=0.
- alu_out_wb, result_wb and rd_wb are copied unchanged. reg_write_wb = reg_write_m & ~misalign.
- Memory contents are not reset.
- FSM states are IDLE and WAIT, with a counter cnt.
  - IDLE, aligned access, MEM_LAT>0: busy_o=1, go to WAIT, cnt<=MEM_LAT-1, no commit.
  - WAIT, cnt!=0: busy_o=1, cnt decrements.
  - WAIT, cnt==0: busy_o=0, commit, go to IDLE.
  - IDLE with a non-memory op, a misaligned op, or MEM_LAT=0: commit in the same cycle.
- Commit means the store writes memory at the clock edge and the MEM/WB register captures the bundle.
- In any busy cycle, MEM/WB loads a bubble: valid_wb=0, reg_write_wb=0.
- valid_m=0 behaves as a bubble: no access, and MEM/WB captures valid_wb=0.

## Timing
- Priority: rst > flush_i > stall_i > normal.
- Reset: FSM goes to IDLE, cnt=0, every MEM/WB output=0, busy_o=0. Reset mid-WAIT abandons the access with no write.
- flush_i: MEM/WB captures a bubble, FSM goes to IDLE, and a pending or committing store is suppressed. busy_o=0 in that cycle.
- stall_i (without flush): MEM/WB, FSM and cnt hold; no memory write. busy_o keeps its state-derived value.
- Latency: non-memory ops and memory ops with MEM_LAT=0 take 1 edge. Aligned memory ops take MEM_LAT+1 edges, plus any stall cycles.
- busy_o is combinational from state, inputs and cnt.
- Read-after-write: a load in the cycle after a store commit returns the new data. Memory read is combinational from the array.

## Structure
- Package mem_stage_pkg holds:
  - size codes (SZ_B, SZ_H, SZ_W, SZ_D);
  - the FSM state enum;
  - functions for lane-mask generation, lane extract/extend and the alignment check.
- Sub-module dmem_bank: DEPTH×DATA_W array with a per-byte write enable and combinational read.
- mem_wb_stage contains the FSM, the alignment logic and the MEM/WB register.

## Test plan
Default parameters unless noted.
- **Word store/load:** sw 0x00000063 to addr 0x08, then lw from 0x08. Required: dm_rd_out_wb=0x00000063 and valid_wb=1 one edge after the load; alu_out_wb=0x08.
- **Byte store, signed/unsigned load:** sb 0x80 to addr 0x0D, then lb from 0x0D. Required: 0xFFFFFF80. Then lbu from 0x0D. Required: 0x00000080. lw from 0x0C returns 0x00008000 (on a zeroed word).
- **Misaligned store:** sw 0xDEADBEEF to addr 0x09. Required: misalign_wb=1, reg_write_wb=0, busy_o never asserts. A following lw from 0x08 returns the prior value unchanged.
- **Multi-cycle latency:** with MEM_LAT=2, lw is held at the input. Required: busy_o high for 2 cycles; valid_wb=0 after edges 1 and 2; data with valid_wb=1 after edge 3. A non-memory op takes 1 edge.
- **Flush and stall mid-access:** with MEM_LAT=2, an sw to 0x10 is presented, then flush_i is asserted in its commit cycle. Required: no write (lw 0x10 returns the old value) and valid_wb=0. Separately, stall_i asserted for 3 cycles during a lw. Required: all MEM/WB outputs hold for those 3 cycles and commit happens 3 cycles late.
- **Reset mid-WAIT:** rst asserted during a MEM_LAT=3 store. Required: all outputs 0 after the next edge, FSM in IDLE, memory not written.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access size codes, the
// access FSM states and the byte-lane helper functions.
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_e;

  // A full-width access on a 32-bit datapath is just a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size, input int bytes);
    logic [1:0] s;
    s = size;
    if (size == SZ_D && bytes == 4) s = SZ_W;
    return s;
  endfunction

  // Byte-lane enables for an access of the given size at lane offset off.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01 << off;
      SZ_H:    m = 8'h03 << off;
      SZ_W:    m = 8'h0F << off;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Natural alignment: the lane offset must be a multiple of the access size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (off[0] == 1'b0);
      SZ_W:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  // Pull the addressed lanes down to bit 0 and sign- or zero-extend them.
  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [1:0] size,
                                               input logic [2:0] off, input logic uns);
    logic [63:0] sh;
    logic [63:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    r = {{56{~uns & sh[7]}}, sh[7:0]};
      SZ_H:    r = {{48{~uns & sh[15]}}, sh[15:0]};
      SZ_W:    r = {{32{~uns & sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_bank.sv
// Data memory bank: DEPTH words of DATA_W bits, per-byte write enables,
// asynchronous read so a load sees a store committed on the previous edge.
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic [DATA_W/8-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write only the enabled byte lanes; the others keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Pipeline memory stage: byte/half/word/full loads and stores with optional
// fixed extra latency, misalignment trapping, and the MEM/WB register.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] dm_wd_m,
  input  logic              dm_write_m,
  input  logic              dm_read_m,
  input  logic [1:0]        size_m,
  input  logic              unsigned_m,
  input  logic              result_m,
  input  logic [4:0]        rd_m,
  input  logic              reg_write_m,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              valid_wb,
  output logic [DATA_W-1:0] alu_out_wb,
  output logic [DATA_W-1:0] dm_rd_out_wb,
  output logic              result_wb,
  output logic [4:0]        rd_wb,
  output logic              reg_write_wb,
  output logic              misalign_wb
);

  localparam int         BYTES    = DATA_W / 8;
  localparam int         ADDR_LSB = $clog2(BYTES);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam bit         HAS_LAT  = (MEM_LAT > 0);
  localparam logic [2:0] LAT_M1   = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

  mem_state_e        state;
  logic [2:0]        cnt;

  logic [IDX_W-1:0]  word_idx;
  logic [2:0]        lane_off;
  logic [1:0]        size_e;
  logic              mem_op;
  logic              aligned;
  logic              misalign;
  logic              access;
  logic [7:0]        mask8;
  logic [BYTES-1:0]  lane_be;
  logic [BYTES-1:0]  bank_we;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [63:0]       load64;
  logic [DATA_W-1:0] load_val;
  logic              commit;
  logic              store_we;
  logic              unused_bits;

  assign word_idx = alu_out_m[ADDR_LSB +: IDX_W];
  assign lane_off = 3'(alu_out_m[ADDR_LSB-1:0]);
  assign size_e   = eff_size(size_m, BYTES);
  assign mem_op   = valid_m & (dm_write_m | dm_read_m);
  assign aligned  = is_aligned(size_e, lane_off);
  assign misalign = mem_op & ~aligned;
  assign access   = mem_op & aligned;
  assign mask8    = lane_mask(size_e, lane_off);
  assign lane_be  = mask8[BYTES-1:0];
  assign wr_data  = dm_wd_m << {lane_off, 3'b000};
  assign load64   = load_extract(64'(rd_word), size_e, lane_off, unsigned_m);
  assign load_val = load64[DATA_W-1:0];

  assign unused_bits = ^{alu_out_m, load64, mask8};

  // Decide from state and inputs whether this cycle is a wait cycle (busy)
  // or the cycle in which the instruction retires into MEM/WB (commit).
  // Reset and flush override both so nothing is held or written.
  always_comb begin
    busy_o = 1'b0;
    commit = 1'b0;
    if (!rst && !flush_i) begin
      case (state)
        IDLE: begin
          if (access && HAS_LAT) busy_o = 1'b1;
          else                   commit = 1'b1;
        end
        WAIT: begin
          if (cnt != 3'd0) busy_o = 1'b1;
          else             commit = 1'b1;
        end
      endcase
    end
  end

  assign store_we = commit & ~stall_i & access & dm_write_m;
  assign bank_we  = store_we ? lane_be : '0;

  dmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .addr  (word_idx),
    .wdata (wr_data),
    .rdata (rd_word)
  );

  // Access FSM: an aligned memory op with extra latency parks in WAIT and
  // counts down; flush or reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else if (!stall_i) begin
      case (state)
        IDLE: begin
          if (access && HAS_LAT) begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) cnt   <= cnt - 3'd1;
          else             state <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: capture the retiring bundle on commit, otherwise insert
  // a bubble; stall freezes it.
  always_ff @(posedge clk) begin
    if (rst || flush_i || (!stall_i && !(commit && valid_m))) begin
      valid_wb     <= 1'b0;
      alu_out_wb   <= '0;
      dm_rd_out_wb <= '0;
      result_wb    <= 1'b0;
      rd_wb        <= 5'd0;
      reg_write_wb <= 1'b0;
      misalign_wb  <= 1'b0;
    end else if (!stall_i) begin
      valid_wb     <= 1'b1;
      alu_out_wb   <= alu_out_m;
      dm_rd_out_wb <= (access && dm_read_m) ? load_val : '0;
      result_wb    <= result_m;
      rd_wb        <= rd_m;
      reg_write_wb <= reg_write_m & ~misalign;
      misalign_wb  <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: three instances (MEM_LAT 0, 2, 3), only
// one out of reset at a time, with a scoreboard of expected MEM/WB bundles.
module tb_mem_wb_stage;

  localparam int NDUT = 3;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    logic        mis;
    logic        regw;
    logic [4:0]  rd;
    logic        res;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a [NDUT];
  logic        valid_m, dm_write_m, dm_read_m, unsigned_m, result_m, reg_write_m;
  logic [31:0] alu_out_m, dm_wd_m;
  logic [1:0]  size_m;
  logic [4:0]  rd_m;
  logic        stall_i, flush_i;

  logic        busy_a     [NDUT];
  logic        valid_a    [NDUT];
  logic [31:0] alu_a      [NDUT];
  logic [31:0] data_a     [NDUT];
  logic        res_a      [NDUT];
  logic [4:0]  rd_a       [NDUT];
  logic        regw_a     [NDUT];
  logic        mis_a      [NDUT];

  int   sel = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_wb_stage #(
      .DATA_W  (32),
      .DEPTH   (256),
      .MEM_LAT ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk          (clk),
      .rst          (rst_a[g]),
      .valid_m      (valid_m),
      .alu_out_m    (alu_out_m),
      .dm_wd_m      (dm_wd_m),
      .dm_write_m   (dm_write_m),
      .dm_read_m    (dm_read_m),
      .size_m       (size_m),
      .unsigned_m   (unsigned_m),
      .result_m     (result_m),
      .rd_m         (rd_m),
      .reg_write_m  (reg_write_m),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .busy_o       (busy_a[g]),
      .valid_wb     (valid_a[g]),
      .alu_out_wb   (alu_a[g]),
      .dm_rd_out_wb (data_a[g]),
      .result_wb    (res_a[g]),
      .rd_wb        (rd_a[g]),
      .reg_write_wb (regw_a[g]),
      .misalign_wb  (mis_a[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic modelAligned(input logic [1:0] sz, input logic [31:0] addr);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return addr[0] == 1'b0;
      default: return addr[1:0] == 2'b00;
    endcase
  endfunction

  task automatic idleInputs();
    valid_m = 1'b0; dm_write_m = 1'b0; dm_read_m = 1'b0; size_m = SZ_W;
    unsigned_m = 1'b0; result_m = 1'b0; rd_m = 5'd0; reg_write_m = 1'b0;
    alu_out_m = 32'd0; dm_wd_m = 32'd0;
  endtask

  task automatic applyStimulus(input string tag, input logic wr, input logic rdq,
                               input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] rdr, input logic regw,
                               input logic res, input logic [31:0] exp_data, input bit push);
    exp_t e;
    valid_m = 1'b1; dm_write_m = wr; dm_read_m = rdq; size_m = sz; unsigned_m = uns;
    alu_out_m = addr; dm_wd_m = wd; rd_m = rdr; reg_write_m = regw; result_m = res;
    if (push) begin
      e.tag  = tag;
      e.alu  = addr;
      e.mis  = (wr | rdq) & ~modelAligned(sz, addr);
      e.data = e.mis ? 32'd0 : exp_data;
      e.regw = regw & ~e.mis;
      e.rd   = rdr;
      e.res  = res;
      sb_q.push_back(e);
    end
    #1;
  endtask

  task automatic commitOp(input int lat);
    int   edges = 0;
    int   busy_cycles = 0;
    exp_t e;
    while (1) begin
      if (busy_a[sel] === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      edges++;
      if (valid_a[sel] === 1'b1) break;
      checkOutput("bubble_regw", 32'(regw_a[sel]), 32'd0);
      if (edges >= 20) begin
        checkOutput("commit_timeout", 32'(valid_a[sel]), 32'd1);
        break;
      end
    end
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({e.tag, "_edges"}, 32'(edges), 32'(lat + 1));
      checkOutput({e.tag, "_busy"}, 32'(busy_cycles), 32'(lat));
      checkOutput({e.tag, "_alu"}, alu_a[sel], e.alu);
      checkOutput({e.tag, "_data"}, data_a[sel], e.data);
      checkOutput({e.tag, "_mis"}, 32'(mis_a[sel]), 32'(e.mis));
      checkOutput({e.tag, "_regw"}, 32'(regw_a[sel]), 32'(e.regw));
      checkOutput({e.tag, "_rd"}, 32'(rd_a[sel]), 32'(e.rd));
      checkOutput({e.tag, "_res"}, 32'(res_a[sel]), 32'(e.res));
    end
  endtask

  task automatic resetDut(input int idx);
    for (int i = 0; i < NDUT; i++) rst_a[i] = 1'b1;
    sel = idx;
    idleInputs();
    stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a[idx] = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid_a[sel]), 32'd0);
    checkOutput({tag, "_alu"}, alu_a[sel], 32'd0);
    checkOutput({tag, "_data"}, data_a[sel], 32'd0);
    checkOutput({tag, "_res"}, 32'(res_a[sel]), 32'd0);
    checkOutput({tag, "_rd"}, 32'(rd_a[sel]), 32'd0);
    checkOutput({tag, "_regw"}, 32'(regw_a[sel]), 32'd0);
    checkOutput({tag, "_mis"}, 32'(mis_a[sel]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NDUT; i++) rst_a[i] = 1'b1;
    idleInputs();
    stall_i = 1'b0; flush_i = 1'b0;

    // ---- MEM_LAT = 0 ----
    resetDut(0);
    checkAllZero("reset0");
    checkOutput("reset0_busy", 32'(busy_a[sel]), 32'd0);

    applyStimulus("sw08", 1, 0, SZ_W, 0, 32'h08, 32'h63, 5'd0, 0, 0, 32'd0, 1);
    commitOp(0);
    applyStimulus("lw08", 0, 1, SZ_W, 0, 32'h08, 32'd0, 5'd1, 1, 1, 32'h63, 1);
    commitOp(0);
    applyStimulus("sw0C", 1, 0, SZ_W, 0, 32'h0C, 32'h0, 5'd0, 0, 0, 32'd0, 1);
    commitOp(0);
    applyStimulus("sb0D", 1, 0, SZ_B, 0, 32'h0D, 32'h12345680, 5'd0, 0, 0, 32'd0, 1);
    commitOp(0);
    applyStimulus("lb0D", 0, 1, SZ_B, 0, 32'h0D, 32'd0, 5'd2, 1, 1, 32'hFFFFFF80, 1);
    commitOp(0);
    applyStimulus("lbu0D", 0, 1, SZ_B, 1, 32'h0D, 32'd0, 5'd3, 1, 1, 32'h00000080, 1);
    commitOp(0);
    applyStimulus("lw0C", 0, 1, SZ_W, 0, 32'h0C, 32'd0, 5'd4, 1, 1, 32'h00008000, 1);
    commitOp(0);
    applyStimulus("lh0C", 0, 1, SZ_H, 0, 32'h0C, 32'd0, 5'd5, 1, 1, 32'hFFFF8000, 1);
    commitOp(0);
    applyStimulus("lhu0E", 0, 1, SZ_H, 1, 32'h0E, 32'd0, 5'd6, 1, 1, 32'h0, 1);
    commitOp(0);
    applyStimulus("sw09_mis", 1, 0, SZ_W, 0, 32'h09, 32'hDEADBEEF, 5'd0, 0, 0, 32'd0, 1);
    commitOp(0);
    applyStimulus("lw0A_mis", 0, 1, SZ_W, 0, 32'h0A, 32'd0, 5'd7, 1, 1, 32'd0, 1);
    commitOp(0);
    applyStimulus("lw08_after", 0, 1, SZ_W, 0, 32'h08, 32'd0, 5'd8, 1, 0, 32'h63, 1);
    commitOp(0);
    applyStimulus("alu_op", 0, 0, SZ_W, 0, 32'h0000CAFE, 32'd0, 5'd9, 1, 1, 32'd0, 1);
    commitOp(0);
    idleInputs();
    @(posedge clk); #1;
    checkOutput("bubble_valid", 32'(valid_a[sel]), 32'd0);

    // ---- MEM_LAT = 2 ----
    resetDut(1);
    applyStimulus("alu_op_lat2", 0, 0, SZ_W, 0, 32'h00001234, 32'd0, 5'd3, 1, 0, 32'd0, 1);
    commitOp(0);
    applyStimulus("sw10_lat2", 1, 0, SZ_W, 0, 32'h10, 32'h11111111, 5'd0, 0, 0, 32'd0, 1);
    commitOp(2);
    applyStimulus("lw10_lat2", 0, 1, SZ_W, 0, 32'h10, 32'd0, 5'd5, 1, 1, 32'h11111111, 1);
    commitOp(2);
    applyStimulus("lw12_mis_lat2", 0, 1, SZ_W, 0, 32'h12, 32'd0, 5'd6, 1, 0, 32'd0, 1);
    commitOp(0);

    // Store is flushed in its commit cycle
    applyStimulus("sw10_flush", 1, 0, SZ_W, 0, 32'h10, 32'h22222222, 5'd0, 0, 0, 32'd0, 0);
    checkOutput("flush_busy_c0", 32'(busy_a[sel]), 32'd1);
    @(posedge clk); #1;
    checkOutput("flush_busy_c1", 32'(busy_a[sel]), 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b1;
    #1;
    checkOutput("flush_busy_commit", 32'(busy_a[sel]), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    checkOutput("flush_valid", 32'(valid_a[sel]), 32'd0);
    applyStimulus("lw10_postflush", 0, 1, SZ_W, 0, 32'h10, 32'd0, 5'd5, 1, 1, 32'h11111111, 1);
    commitOp(2);

    // Stall for 3 cycles as the next load is presented
    applyStimulus("lw10_stall", 0, 1, SZ_W, 0, 32'h10, 32'd0, 5'd7, 1, 0, 32'h11111111, 1);
    stall_i = 1'b1;
    #1;
    checkOutput("stall_busy", 32'(busy_a[sel]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_hold_valid", 32'(valid_a[sel]), 32'd1);
      checkOutput("stall_hold_rd", 32'(rd_a[sel]), 32'd5);
      checkOutput("stall_hold_data", data_a[sel], 32'h11111111);
      checkOutput("stall_hold_regw", 32'(regw_a[sel]), 32'd1);
    end
    stall_i = 1'b0;
    #1;
    commitOp(2);

    // ---- MEM_LAT = 3 ----
    resetDut(2);
    applyStimulus("sw20_lat3", 1, 0, SZ_W, 0, 32'h20, 32'hAAAAAAAA, 5'd0, 0, 0, 32'd0, 1);
    commitOp(3);
    applyStimulus("sw20_reset", 1, 0, SZ_W, 0, 32'h20, 32'hBBBBBBBB, 5'd0, 0, 0, 32'd0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a[2] = 1'b1;
    @(posedge clk); #1;
    checkAllZero("rst_midwait");
    rst_a[2] = 1'b0;
    idleInputs();
    #1;
    checkOutput("rst_midwait_busy", 32'(busy_a[sel]), 32'd0);
    applyStimulus("lw20_postrst", 0, 1, SZ_W, 0, 32'h20, 32'd0, 5'd2, 1, 1, 32'hAAAAAAAA, 1);
    commitOp(3);

    idleInputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
